// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: machine-mode CSR access sequencer for the execute stage.
// Takes one CSR-class request at a time (CSRRW/CSRRS/CSRRC/ECALL/MRET/illegal).
// It runs the read-modify-write or trap/return sequence against the CSR file.
// It then returns the old CSR value and any PC redirect through a valid/ready
// response handshake.
module csr_access_ctrl #(
   parameter logic [31:0] MCAUSE_ECALL   = 32'd11,
   parameter logic [31:0] MCAUSE_ILLEGAL = 32'd2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_src,
   input  logic        req_src_zero,
   input  logic [31:0] req_pc,
   output logic [11:0] csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic        csr_wen,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        exception_en,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mcause_wdata,
   input  logic [31:0] mtvec_rdata,
   input  logic [31:0] mepc_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_redirect,
   output logic [31:0] rsp_target
);

   localparam logic [2:0] OP_RW    = 3'd1;
   localparam logic [2:0] OP_RS    = 3'd2;
   localparam logic [2:0] OP_RC    = 3'd3;
   localparam logic [2:0] OP_ECALL = 3'd4;
   localparam logic [2:0] OP_MRET  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_TRAP  = 3'd3,
      S_RET   = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t      state_q;

   // Latched request fields
   logic [2:0]  op_q;
   logic [11:0] addr_q;
   logic [31:0] src_q;
   logic        src_zero_q;
   logic [31:0] old_q;

   // Registered outputs
   logic        req_ready_q;
   logic [11:0] csr_raddr_q;
   logic        csr_wen_q;
   logic [11:0] csr_waddr_q;
   logic [31:0] csr_wdata_q;
   logic        exception_en_q;
   logic [31:0] mepc_wdata_q;
   logic [31:0] mcause_wdata_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_redirect_q;
   logic [31:0] rsp_target_q;

   // Next write value for the read-modify-write, computed from the live read data
   logic [31:0] wdata_d;
   logic        wen_d;

   // Bitwise read-modify-write: RW replaces, RS sets bits, RC clears bits
   function automatic logic [31:0] rmw_data(input logic [2:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] src);
      logic [31:0] res;
      res = old;
      case (op)
         OP_RW:   res = src;
         OP_RS:   res = old | src;
         OP_RC:   res = old & ~src;
         default: res = old;
      endcase
      return res;
   endfunction

   // Set/clear ops with a zero source must not write, but the WRITE cycle is still spent
   function automatic logic write_enabled(input logic [2:0] op, input logic src_zero);
      return !(((op == OP_RS) || (op == OP_RC)) && src_zero);
   endfunction

   // Write-data/enable for the WRITE cycle, derived from the CSR value being read now
   always_comb begin
      wdata_d = rmw_data(op_q, csr_rdata, src_q);
      wen_d   = write_enabled(op_q, src_zero_q);
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         op_q           <= 3'd0;
         addr_q         <= 12'd0;
         src_q          <= 32'd0;
         src_zero_q     <= 1'b0;
         old_q          <= 32'd0;
         req_ready_q    <= 1'b1;
         csr_raddr_q    <= 12'd0;
         csr_wen_q      <= 1'b0;
         csr_waddr_q    <= 12'd0;
         csr_wdata_q    <= 32'd0;
         exception_en_q <= 1'b0;
         mepc_wdata_q   <= 32'd0;
         mcause_wdata_q <= 32'd0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= 32'd0;
         rsp_redirect_q <= 1'b0;
         rsp_target_q   <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  op_q        <= req_op;
                  addr_q      <= req_addr;
                  src_q       <= req_src;
                  src_zero_q  <= req_src_zero;
                  case (req_op)
                     OP_RW, OP_RS, OP_RC: begin
                        state_q     <= S_READ;
                        csr_raddr_q <= req_addr;
                     end
                     OP_MRET: begin
                        state_q <= S_RET;
                     end
                     default: begin
                        // ECALL and every unrecognised op take the trap path
                        state_q        <= S_TRAP;
                        exception_en_q <= 1'b1;
                        mepc_wdata_q   <= req_pc;
                        mcause_wdata_q <= (req_op == OP_ECALL) ? MCAUSE_ECALL : MCAUSE_ILLEGAL;
                     end
                  endcase
               end
            end
            S_READ: begin
               state_q     <= S_WRITE;
               old_q       <= csr_rdata;
               csr_raddr_q <= 12'd0;
               csr_waddr_q <= addr_q;
               csr_wdata_q <= wdata_d;
               csr_wen_q   <= wen_d;
            end
            S_WRITE: begin
               state_q        <= S_RESP;
               csr_wen_q      <= 1'b0;
               csr_waddr_q    <= 12'd0;
               csr_wdata_q    <= 32'd0;
               rsp_valid_q    <= 1'b1;
               rsp_rdata_q    <= old_q;
               rsp_redirect_q <= 1'b0;
               rsp_target_q   <= 32'd0;
            end
            S_TRAP: begin
               state_q        <= S_RESP;
               exception_en_q <= 1'b0;
               mepc_wdata_q   <= 32'd0;
               mcause_wdata_q <= 32'd0;
               rsp_valid_q    <= 1'b1;
               rsp_rdata_q    <= 32'd0;
               rsp_redirect_q <= 1'b1;
               rsp_target_q   <= mtvec_rdata;
            end
            S_RET: begin
               state_q        <= S_RESP;
               rsp_valid_q    <= 1'b1;
               rsp_rdata_q    <= 32'd0;
               rsp_redirect_q <= 1'b1;
               rsp_target_q   <= mepc_rdata;
            end
            S_RESP: begin
               // Response fields hold until the consumer takes them; no IDLE bypass
               if (rsp_ready) begin
                  state_q        <= S_IDLE;
                  req_ready_q    <= 1'b1;
                  rsp_valid_q    <= 1'b0;
                  rsp_rdata_q    <= 32'd0;
                  rsp_redirect_q <= 1'b0;
                  rsp_target_q   <= 32'd0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Strobes and handshakes are masked during reset so nothing fires in the reset cycle
   assign req_ready    = req_ready_q    & ~reset;
   assign rsp_valid    = rsp_valid_q    & ~reset;
   assign csr_wen      = csr_wen_q      & ~reset;
   assign exception_en = exception_en_q & ~reset;

   assign csr_raddr    = csr_raddr_q;
   assign csr_waddr    = csr_waddr_q;
   assign csr_wdata    = csr_wdata_q;
   assign mepc_wdata   = mepc_wdata_q;
   assign mcause_wdata = mcause_wdata_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_redirect = rsp_redirect_q;
   assign rsp_target   = rsp_target_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed testbench for csr_access_ctrl.
module tb_csr_access_ctrl;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_src;
   logic        req_src_zero;
   logic [31:0] req_pc;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_wen;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        exception_en;
   logic [31:0] mepc_wdata;
   logic [31:0] mcause_wdata;
   logic [31:0] mtvec_rdata;
   logic [31:0] mepc_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_redirect;
   logic [31:0] rsp_target;

   int n_checks;
   int n_fail;

   csr_access_ctrl dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
      .req_pc(req_pc),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .exception_en(exception_en), .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
      .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_redirect(rsp_redirect), .rsp_target(rsp_target)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // CSR file read port: mstatus holds 0x1800, the 0x305 slot reads 0, unknown addresses read 0
   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         12'h300: csr_rdata = 32'h0000_1800;
         12'h305: csr_rdata = 32'h0000_0000;
         default: csr_rdata = 32'd0;
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request for one edge, then withdraw it; returns positioned at T+1
   task automatic accept(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic zero, input logic [31:0] pc);
      req_valid = 1'b1; req_op = op; req_addr = addr;
      req_src = src; req_src_zero = zero; req_pc = pc;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_checks++;
      if ({req_ready, rsp_valid, csr_wen, exception_en} !== 4'b0000) begin
         $display("FAIL reset_hold_strobes got=%b want=0000", {req_ready, rsp_valid, csr_wen, exception_en});
         n_fail++;
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         $display("FAIL reset_req_ready got=%b want=1", req_ready); n_fail++;
      end
      n_checks++;
      if ({csr_raddr, csr_wen, csr_waddr, csr_wdata, exception_en, mepc_wdata, mcause_wdata,
           rsp_valid, rsp_rdata, rsp_redirect, rsp_target} !== '0) begin
         $display("FAIL reset_outputs_zero raddr=%h wen=%b waddr=%h wdata=%h exc=%b mepc=%h mcause=%h rv=%b rd=%h redir=%b tgt=%h want all 0",
                  csr_raddr, csr_wen, csr_waddr, csr_wdata, exception_en, mepc_wdata, mcause_wdata,
                  rsp_valid, rsp_rdata, rsp_redirect, rsp_target);
         n_fail++;
      end
   endtask

   task automatic test_csrrw();
      accept(3'd1, 12'h305, 32'h8000_0100, 1'b0, 32'h0);
      n_checks++;
      if (csr_raddr !== 12'h305 || req_ready !== 1'b0) begin
         $display("FAIL rw_read raddr=%h ready=%b want 305/0", csr_raddr, req_ready); n_fail++;
      end
      tick();
      n_checks++;
      if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h305, 32'h8000_0100}) begin
         $display("FAIL rw_write wen=%b waddr=%h wdata=%h want 1/305/80000100", csr_wen, csr_waddr, csr_wdata);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_rdata, rsp_redirect, rsp_target, csr_wen} !== {1'b1, 32'h0, 1'b0, 32'h0, 1'b0}) begin
         $display("FAIL rw_resp valid=%b rdata=%h redir=%b tgt=%h wen=%b want 1/0/0/0/0",
                  rsp_valid, rsp_rdata, rsp_redirect, rsp_target, csr_wen);
         n_fail++;
      end
      tick();
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_raddr !== 12'h0) begin
         $display("FAIL rw_idle ready=%b valid=%b raddr=%h want 1/0/000", req_ready, rsp_valid, csr_raddr);
         n_fail++;
      end
   endtask

   task automatic test_csrrs_rc();
      accept(3'd2, 12'h300, 32'h8, 1'b0, 32'h0);
      tick();
      n_checks++;
      if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h300, 32'h0000_1808}) begin
         $display("FAIL rs_write wen=%b waddr=%h wdata=%h want 1/300/00001808", csr_wen, csr_waddr, csr_wdata);
         n_fail++;
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1800) begin
         $display("FAIL rs_resp valid=%b rdata=%h want 1/00001800", rsp_valid, rsp_rdata); n_fail++;
      end
      tick();
      // CSRRC with zero source: write suppressed in every cycle
      accept(3'd3, 12'h300, 32'h0, 1'b1, 32'h0);
      n_checks++;
      if (csr_wen !== 1'b0) begin
         $display("FAIL rc_zero_wen_t1 got=%b want=0", csr_wen); n_fail++;
      end
      tick();
      n_checks++;
      if (csr_wen !== 1'b0) begin
         $display("FAIL rc_zero_wen_t2 got=%b want=0", csr_wen); n_fail++;
      end
      tick();
      n_checks++;
      if (csr_wen !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h1800) begin
         $display("FAIL rc_zero_resp wen=%b valid=%b rdata=%h want 0/1/00001800", csr_wen, rsp_valid, rsp_rdata);
         n_fail++;
      end
      tick();
      // CSRRC with a real mask clears bit 11
      accept(3'd3, 12'h300, 32'h0000_0800, 1'b0, 32'h0);
      tick();
      n_checks++;
      if ({csr_wen, csr_wdata} !== {1'b1, 32'h0000_1000}) begin
         $display("FAIL rc_write wen=%b wdata=%h want 1/00001000", csr_wen, csr_wdata); n_fail++;
      end
      tick(); tick();
   endtask

   task automatic test_trap();
      mtvec_rdata = 32'h8000_0100;
      accept(3'd4, 12'h0, 32'h0, 1'b0, 32'h8000_0010);
      n_checks++;
      if ({exception_en, mepc_wdata, mcause_wdata, csr_wen} !== {1'b1, 32'h8000_0010, 32'd11, 1'b0}) begin
         $display("FAIL ecall_trap exc=%b mepc=%h mcause=%0d wen=%b want 1/80000010/11/0",
                  exception_en, mepc_wdata, mcause_wdata, csr_wen);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_redirect, rsp_target, rsp_rdata, exception_en, mcause_wdata}
          !== {1'b1, 1'b1, 32'h8000_0100, 32'h0, 1'b0, 32'h0}) begin
         $display("FAIL ecall_resp valid=%b redir=%b tgt=%h rdata=%h exc=%b mcause=%h want 1/1/80000100/0/0/0",
                  rsp_valid, rsp_redirect, rsp_target, rsp_rdata, exception_en, mcause_wdata);
         n_fail++;
      end
      tick();
      accept(3'd7, 12'h0, 32'h0, 1'b0, 32'h8000_0020);
      n_checks++;
      if ({exception_en, mepc_wdata, mcause_wdata} !== {1'b1, 32'h8000_0020, 32'd2}) begin
         $display("FAIL illegal_trap exc=%b mepc=%h mcause=%0d want 1/80000020/2",
                  exception_en, mepc_wdata, mcause_wdata);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_redirect, rsp_target} !== {1'b1, 1'b1, 32'h8000_0100}) begin
         $display("FAIL illegal_resp valid=%b redir=%b tgt=%h want 1/1/80000100", rsp_valid, rsp_redirect, rsp_target);
         n_fail++;
      end
      tick();
   endtask

   task automatic test_mret();
      mepc_rdata = 32'h8000_0014;
      accept(3'd5, 12'h0, 32'h0, 1'b0, 32'h0);
      n_checks++;
      if (csr_wen !== 1'b0 || exception_en !== 1'b0 || rsp_valid !== 1'b0) begin
         $display("FAIL mret_t1 wen=%b exc=%b valid=%b want 0/0/0", csr_wen, exception_en, rsp_valid); n_fail++;
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_redirect, rsp_target, rsp_rdata, csr_wen, exception_en}
          !== {1'b1, 1'b1, 32'h8000_0014, 32'h0, 1'b0, 1'b0}) begin
         $display("FAIL mret_resp valid=%b redir=%b tgt=%h rdata=%h wen=%b exc=%b want 1/1/80000014/0/0/0",
                  rsp_valid, rsp_redirect, rsp_target, rsp_rdata, csr_wen, exception_en);
         n_fail++;
      end
      tick();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      accept(3'd1, 12'h300, 32'h55, 1'b0, 32'h0);
      tick(); tick();
      // Offer a competing request while the response is stalled
      req_valid = 1'b1; req_op = 3'd2; req_addr = 12'h305; req_src = 32'h1; req_src_zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({rsp_valid, rsp_rdata, rsp_redirect, rsp_target, req_ready, csr_raddr}
             !== {1'b1, 32'h1800, 1'b0, 32'h0, 1'b0, 12'h0}) begin
            $display("FAIL bp_hold_%0d valid=%b rdata=%h redir=%b tgt=%h ready=%b raddr=%h want 1/1800/0/0/0/000",
                     i, rsp_valid, rsp_rdata, rsp_redirect, rsp_target, req_ready, csr_raddr);
            n_fail++;
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || csr_raddr !== 12'h0) begin
         $display("FAIL bp_no_bypass valid=%b ready=%b raddr=%h want 0/1/000", rsp_valid, req_ready, csr_raddr);
         n_fail++;
      end
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (csr_raddr !== 12'h305 || req_ready !== 1'b0) begin
         $display("FAIL bp_next_accept raddr=%h ready=%b want 305/0", csr_raddr, req_ready); n_fail++;
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid_op();
      accept(3'd1, 12'h305, 32'h1234, 1'b0, 32'h0);
      tick();
      reset = 1'b1;
      #1;
      n_checks++;
      if (csr_wen !== 1'b0 || rsp_valid !== 1'b0) begin
         $display("FAIL rst_write_cycle wen=%b valid=%b want 0/0", csr_wen, rsp_valid); n_fail++;
      end
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_wen !== 1'b0) begin
         $display("FAIL rst_write_after ready=%b valid=%b wen=%b want 1/0/0", req_ready, rsp_valid, csr_wen);
         n_fail++;
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         $display("FAIL rst_write_dropped valid=%b ready=%b want 0/1", rsp_valid, req_ready); n_fail++;
      end
      accept(3'd4, 12'h0, 32'h0, 1'b0, 32'h8000_0040);
      reset = 1'b1;
      #1;
      n_checks++;
      if (exception_en !== 1'b0 || rsp_valid !== 1'b0) begin
         $display("FAIL rst_trap_cycle exc=%b valid=%b want 0/0", exception_en, rsp_valid); n_fail++;
      end
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, exception_en, mepc_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         $display("FAIL rst_trap_after ready=%b valid=%b exc=%b mepc=%h want 1/0/0/0",
                  req_ready, rsp_valid, exception_en, mepc_wdata);
         n_fail++;
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_redirect !== 1'b0) begin
         $display("FAIL rst_trap_dropped valid=%b redir=%b want 0/0", rsp_valid, rsp_redirect); n_fail++;
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 12'h0;
      req_src = 32'h0; req_src_zero = 1'b0; req_pc = 32'h0;
      mtvec_rdata = 32'h0; mepc_rdata = 32'h0; rsp_ready = 1'b1;
      #1;
      test_reset();
      test_csrrw();
      test_csrrs_rc();
      test_trap();
      test_mret();
      test_backpressure();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Sequencer that drives the machine-mode CSR register file from the execute stage. It accepts one CSR-class request at a time: CSRRW, CSRRS, CSRRC, ECALL, MRET, or an illegal op. It performs the read-modify-write or trap/return sequence on the CSR file's read/write/exception ports, then returns the old CSR value and any PC redirect through a response handshake.

Parameters:
MCAUSE_ECALL, 32'd11, mcause value written on ECALL from M-mode
MCAUSE_ILLEGAL, 32'd2, mcause value written on an illegal req_op

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  3  1=CSRRW, 2=CSRRS, 3=CSRRC, 4=ECALL, 5=MRET, other=illegal
req_addr  input  12  CSR address
req_src  input  32  rs1 value or zero-extended zimm
req_src_zero  input  1  rs1 is x0 / zimm is 0; suppresses the write for CSRRS/CSRRC
req_pc  input  32  PC of the requesting instruction
csr_raddr  output  12  CSR file read address
csr_rdata  input  32  CSR file read data, combinational from csr_raddr
csr_wen  output  1  CSR file write enable
csr_waddr  output  12  CSR file write address
csr_wdata  output  32  CSR file write data
exception_en  output  1  CSR file trap-entry strobe
mepc_wdata  output  32  trap mepc value
mcause_wdata  output  32  trap mcause value
mtvec_rdata  input  32  current mtvec
mepc_rdata  input  32  current mepc
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  old CSR value; 0 for ECALL, MRET and illegal ops
rsp_redirect  output  1  PC redirect required
rsp_target  output  32  redirect target; 0 when rsp_redirect=0

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE; all internal registers clear to 0.
  - While reset is high, req_ready, rsp_valid, csr_wen and exception_en are forced to 0.
  - Every output is 0 on the first cycle after reset, except req_ready=1.
- FSM states: IDLE, READ, WRITE, TRAP, RET, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at the clock edge (accept at edge T), latch op, addr, src, src_zero and pc.
  - Next state: op 1-3 go to READ; op 4 and illegal ops go to TRAP; op 5 goes to RET.
- READ (T+1):
  - csr_raddr=latched addr.
  - Register old=csr_rdata at the edge; next state is WRITE.
- WRITE (T+2):
  - csr_waddr=addr.
  - csr_wdata: RW gives src; RS gives old|src; RC gives old&~src.
  - csr_wen=1, except for RS/RC with src_zero=1, where csr_wen=0 and the cycle is still spent.
  - Next state is RESP with rsp_rdata=old, rsp_redirect=0.
- TRAP (T+1):
  - exception_en=1 for exactly one cycle.
  - mepc_wdata=pc.
  - mcause_wdata=MCAUSE_ECALL for op 4, MCAUSE_ILLEGAL otherwise.
  - Latch target=mtvec_rdata; next state is RESP with rsp_redirect=1.
- RET (T+1):
  - Latch target=mepc_rdata; next state is RESP with rsp_redirect=1.
  - No CSR writes occur.
- RESP:
  - rsp_valid=1; all response fields are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE. There is no IDLE bypass, so the next accept comes at the earliest one cycle later.
- Latency from accept edge to first rsp_valid cycle: CSR ops 3 cycles; ECALL, illegal and MRET 2 cycles. Throughput is at most one request per 3 (or 4) cycles.
- Signal levels outside their active states:
  - csr_wen=0 outside WRITE; exception_en=0 outside TRAP.
  - csr_raddr, csr_waddr and csr_wdata are 0 in IDLE.
  - mepc_wdata and mcause_wdata are 0 outside TRAP.
- Unknown CSR addresses are passed through unchanged. The CSR file reads them as 0 and ignores the write, so rsp_rdata=0.
- req_valid is ignored outside IDLE; req_ready=0 outside IDLE.
- Reset mid-operation (any state): the next edge returns to IDLE. The pending response is discarded and no write or trap strobe is issued in the reset cycle.
- Arithmetic is 32-bit bitwise only; there are no carries.

Test Plan:
- CSRRW addr 0x305, src 0x80000100, mtvec=0 → T+1 csr_raddr=0x305; T+2 csr_wen=1, waddr=0x305, wdata=0x80000100; T+3 rsp_valid, rsp_rdata=0, rsp_redirect=0.
- CSRRS addr 0x300, src 0x8, mstatus=0x1800 → WRITE wdata=0x1808, rsp_rdata=0x1800. Repeat as CSRRC with src_zero=1 → csr_wen stays 0 every cycle, rsp_rdata=0x1800.
- ECALL pc 0x80000010, mtvec 0x80000100 → T+1 exception_en=1, mepc_wdata=0x80000010, mcause_wdata=11; T+2 rsp_redirect=1, rsp_target=0x80000100, rsp_rdata=0. With req_op=7 → mcause_wdata=2.
- MRET with mepc 0x80000014 → no csr_wen/exception_en; T+2 rsp_redirect=1, rsp_target=0x80000014.
- Backpressure: rsp_ready=0 for 3 cycles → rsp fields constant, req_ready=0, req_valid ignored; after handshake, next accept no earlier than the following edge.
- Reset asserted while in WRITE (and separately in TRAP) → csr_wen/exception_en=0 in the reset cycle, no rsp_valid, req_ready=1 on the first cycle after reset.
